sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Arbitrates the single 1M×16 audio SRAM between the recorder (write port) and the playback DSP (read port) and drives the SRAM pins directly. Each requester uses a req/ack handshake. Writes have fixed priority, with a starvation guard so playback is never locked out. The block also tracks the highest recorded address so playback can be bounded to valid audio.

## Interface
Parameters:
- WR_STARVE_LIMIT, default 4: maximum number of consecutive write grants allowed while a read is pending.

Ports:
- i_clk  in  1  the single clock for the block.
- i_rst  in  1  asynchronous, active-high reset.
- i_clear  in  1  synchronous; clears the recorded-extent tracker.
- i_rec_req  in  1  recorder write request (level signal).
- i_rec_addr  in  20  write address.
- i_rec_data  in  16  write data.
- o_rec_ack  out  1  one-cycle pulse when the write completes.
- i_dsp_req  in  1  DSP read request (level signal).
- i_dsp_addr  in  20  read address.
- o_dsp_data  out  16  read data; valid with o_dsp_ack and held until the next read ack.
- o_dsp_ack  out  1  one-cycle pulse when the read completes.
- o_last_addr  out  20  highest address written since the last clear.
- o_last_valid  out  1  at least one write has occurred since the last clear.
- o_sram_addr  out  20  SRAM address.
- io_sram_dq  inout  16  SRAM data bus.
- o_sram_ce_n, o_sram_we_n, o_sram_oe_n, o_sram_lb_n, o_sram_ub_n  out  1 each  SRAM controls, active-low.

## Operation
- States: S_IDLE, S_WR1, S_WR2, S_RD1, S_RD2.
- Arbitration happens in S_IDLE only. A request is ignored in the cycle its own ack is high, which prevents double grant.
- Both requests present: the recorder wins unless the starve count equals WR_STARVE_LIMIT, in which case the DSP wins.
- Starve count:
  - increments on each write grant made while i_dsp_req is high;
  - clears on any read grant;
  - saturates at WR_STARVE_LIMIT.
- On grant, the address (and write data) is registered. Requesters must hold addr/data stable from req until ack, and must not drop req before ack.
- S_WR1: ce_n=0, we_n=0, dq driven with the registered data. Next state S_WR2.
- S_WR2: we_n=1, ce_n=0, dq still driven (hold time). Then S_IDLE, with o_rec_ack=1 for one cycle.
- S_RD1: ce_n=0, oe_n=0, dq high-Z. Next state S_RD2.
- S_RD2: same pin values. On exit, dq is captured into o_dsp_data, o_dsp_ack=1 for one cycle, and the state returns to S_IDLE.
- lb_n and ub_n are 0 whenever ce_n=0, otherwise 1.
- Tracker update on write completion: if o_last_valid=0 or addr>o_last_addr, then o_last_addr←addr and o_last_valid←1.
- i_clear sets o_last_addr=0 and o_last_valid=0. If a write completes in the same cycle as i_clear, the write is applied after the clear: the result is last=addr, valid=1.
- Reset values: state S_IDLE, all SRAM controls 1, o_sram_addr 0, dq high-Z, both acks 0, o_dsp_data 0, o_last_addr 0, o_last_valid 0, starve count 0.
- Reset mid-transaction aborts immediately: controls go inactive asynchronously and no ack is issued.

## Timing
- Request seen in S_IDLE at edge k → ack high in the cycle after edge k+2, for both reads and writes.
- Read data is valid in that same ack cycle.
- Throughput: one transaction per 3 cycles (S_IDLE, op1, op2).
- Back-to-back transactions from the same requester are possible when it re-raises req for a new address in the cycle after its ack.
- All outputs are registered. io_sram_dq is driven only in S_WR1 and S_WR2.

## Configuration
- SRAM_BOUND_CHECK_EN defined:
  - A read is out of bounds when o_last_valid=0 or i_dsp_addr>o_last_addr.
  - An out-of-bounds read follows the S_RD1/S_RD2 timing with ce_n and oe_n held at 1.
  - It returns o_dsp_data=16'h0000 with the normal ack.
- SRAM_BOUND_CHECK_EN undefined: every read accesses the SRAM, and the tracker outputs still operate.

## Structure
- Package audio_sram_pkg:
  - state enum;
  - SRAM_AW=20 and SRAM_DW=16;
  - reset constants for the control pins.
- One sub-module, sram_bound_tracker: the last-address register, valid flag, clear handling and the out-of-bounds compare.

## Test plan
- Reset, then a single write of 16'hA5A5 to address 0x00010 → we_n low exactly one cycle; o_rec_ack two cycles after grant; o_last_addr=0x00010.
- Write 16'h1234 to 0x00003, then read 0x00003 → o_dsp_data=16'h1234 in the o_dsp_ack cycle; oe_n low for two cycles.
- Both requests held continuously, WR_STARVE_LIMIT=4 → grant order W,W,W,W,R repeating; no double ack.
- i_clear in the same cycle as a write to 0x00020 completes → o_last_addr=0x00020, o_last_valid=1.
- With SRAM_BOUND_CHECK_EN, o_last_addr=0x00005, read 0x00009 → o_dsp_data=0, ce_n stays 1, ack at the normal latency.
- i_rst asserted during S_WR1 → we_n=1 and dq high-Z asynchronously; no o_rec_ack; state S_IDLE after release.

Source files
------------

// File: rtl/audio_sram_pkg.sv
// Shared types and constants for the audio SRAM port arbiter.
// Optional read bounding is enabled with the SRAM_BOUND_CHECK_EN macro.
package audio_sram_pkg;

    localparam int SRAM_AW = 20;
    localparam int SRAM_DW = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR1,
        S_WR2,
        S_RD1,
        S_RD2
    } state_t;

    // Idle (inactive) levels of the active-low SRAM control pins
    localparam logic CE_N_RST = 1'b1;
    localparam logic WE_N_RST = 1'b1;
    localparam logic OE_N_RST = 1'b1;
    localparam logic BE_N_RST = 1'b1;

endpackage

// File: rtl/sram_bound_tracker.sv
// Tracks the highest recorded address since the last clear and flags reads beyond it.
// The out-of-bounds compare is active only when SRAM_BOUND_CHECK_EN is defined.
module sram_bound_tracker
    import audio_sram_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_clear,
    input  logic               i_wr_done,
    input  logic [SRAM_AW-1:0] i_wr_addr,
    input  logic [SRAM_AW-1:0] i_rd_addr,
    output logic [SRAM_AW-1:0] o_last_addr,
    output logic               o_last_valid,
    output logic               o_oob
);

    // A write completing alongside a clear lands after the clear, so it always wins.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_last_addr  <= '0;
            o_last_valid <= 1'b0;
        end else if (i_wr_done && (i_clear || !o_last_valid || i_wr_addr > o_last_addr)) begin
            o_last_addr  <= i_wr_addr;
            o_last_valid <= 1'b1;
        end else if (i_clear) begin
            o_last_addr  <= '0;
            o_last_valid <= 1'b0;
        end
    end

`ifdef SRAM_BOUND_CHECK_EN
    assign o_oob = !o_last_valid || (i_rd_addr > o_last_addr);
`else
    // Without bounding every read is in range; the read address is don't-care.
    assign o_oob = &{1'b0, i_rd_addr};
`endif

endmodule

// File: rtl/sram_port_arbiter.sv
// Recorder-write / DSP-read arbiter for the 1Mx16 audio SRAM, driving the pins directly.
// SRAM_BOUND_CHECK_EN suppresses SRAM access for reads past the recorded extent.
module sram_port_arbiter
    import audio_sram_pkg::*;
#(
    parameter int WR_STARVE_LIMIT = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_clear,
    input  logic               i_rec_req,
    input  logic [SRAM_AW-1:0] i_rec_addr,
    input  logic [SRAM_DW-1:0] i_rec_data,
    output logic               o_rec_ack,
    input  logic               i_dsp_req,
    input  logic [SRAM_AW-1:0] i_dsp_addr,
    output logic [SRAM_DW-1:0] o_dsp_data,
    output logic               o_dsp_ack,
    output logic [SRAM_AW-1:0] o_last_addr,
    output logic               o_last_valid,
    output logic [SRAM_AW-1:0] o_sram_addr,
    inout  wire  [SRAM_DW-1:0] io_sram_dq,
    output logic               o_sram_ce_n,
    output logic               o_sram_we_n,
    output logic               o_sram_oe_n,
    output logic               o_sram_lb_n,
    output logic               o_sram_ub_n
);

    localparam int SCW = $clog2(WR_STARVE_LIMIT + 1);
    localparam logic [SCW-1:0] STARVE_MAX = SCW'(WR_STARVE_LIMIT);

    state_t             state;
    logic [SCW-1:0]     starve_cnt;
    logic [SRAM_DW-1:0] wr_data;
    logic               dq_oe;
    logic               be_n;
    logic               rd_oob;
    logic               oob_now;
    logic               rec_first;
    logic               rec_grant;
    logic               dsp_grant;

    assign io_sram_dq  = dq_oe ? wr_data : 'z;
    assign o_sram_lb_n = be_n;
    assign o_sram_ub_n = be_n;

    // Priority is decided on raw requests; a just-acked winner stalls the slot for one cycle
    // instead of handing it to the loser, which keeps the starvation ratio exact.
    always_comb begin
        rec_first = i_rec_req && !(i_dsp_req && starve_cnt == STARVE_MAX);
        rec_grant = (state == S_IDLE) && rec_first && !o_rec_ack;
        dsp_grant = (state == S_IDLE) && !rec_first && i_dsp_req && !o_dsp_ack;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= S_IDLE;
            starve_cnt  <= '0;
            wr_data     <= '0;
            dq_oe       <= 1'b0;
            rd_oob      <= 1'b0;
            o_sram_addr <= '0;
            o_sram_ce_n <= CE_N_RST;
            o_sram_we_n <= WE_N_RST;
            o_sram_oe_n <= OE_N_RST;
            be_n        <= BE_N_RST;
            o_rec_ack   <= 1'b0;
            o_dsp_ack   <= 1'b0;
            o_dsp_data  <= '0;
        end else begin
            o_rec_ack <= 1'b0;
            o_dsp_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rec_grant) begin
                        o_sram_addr <= i_rec_addr;
                        wr_data     <= i_rec_data;
                        dq_oe       <= 1'b1;
                        o_sram_ce_n <= 1'b0;
                        o_sram_we_n <= 1'b0;
                        be_n        <= 1'b0;
                        if (i_dsp_req && starve_cnt != STARVE_MAX)
                            starve_cnt <= starve_cnt + 1'b1;
                        state <= S_WR1;
                    end else if (dsp_grant) begin
                        o_sram_addr <= i_dsp_addr;
                        rd_oob      <= oob_now;
                        o_sram_ce_n <= oob_now;
                        o_sram_oe_n <= oob_now;
                        be_n        <= oob_now;
                        starve_cnt  <= '0;
                        state       <= S_RD1;
                    end
                end
                S_WR1: begin
                    o_sram_we_n <= 1'b1;
                    state       <= S_WR2;
                end
                S_WR2: begin
                    o_sram_ce_n <= 1'b1;
                    be_n        <= 1'b1;
                    dq_oe       <= 1'b0;
                    o_rec_ack   <= 1'b1;
                    state       <= S_IDLE;
                end
                S_RD1: state <= S_RD2;
                S_RD2: begin
                    o_sram_ce_n <= 1'b1;
                    o_sram_oe_n <= 1'b1;
                    be_n        <= 1'b1;
                    o_dsp_data  <= rd_oob ? '0 : io_sram_dq;
                    o_dsp_ack   <= 1'b1;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    sram_bound_tracker u_tracker (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_clear      (i_clear),
        .i_wr_done    (state == S_WR2),
        .i_wr_addr    (o_sram_addr),
        .i_rd_addr    (i_dsp_addr),
        .o_last_addr  (o_last_addr),
        .o_last_valid (o_last_valid),
        .o_oob        (oob_now)
    );

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a small SRAM model and an expected-result queue.
module tb_sram_port_arbiter;
    import audio_sram_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clear = 1'b0;
    logic        rec_req = 1'b0;
    logic [19:0] rec_addr = '0;
    logic [15:0] rec_data = '0;
    logic        dsp_req = 1'b0;
    logic [19:0] dsp_addr = '0;
    logic        rec_ack, dsp_ack, last_valid;
    logic        ce_n, we_n, oe_n, lb_n, ub_n;
    logic [15:0] dsp_data;
    logic [19:0] last_addr, sram_addr;
    wire  [15:0] sram_dq;

    always #5 clk = ~clk;

    sram_port_arbiter #(.WR_STARVE_LIMIT(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_clear(clear),
        .i_rec_req(rec_req), .i_rec_addr(rec_addr), .i_rec_data(rec_data), .o_rec_ack(rec_ack),
        .i_dsp_req(dsp_req), .i_dsp_addr(dsp_addr), .o_dsp_data(dsp_data), .o_dsp_ack(dsp_ack),
        .o_last_addr(last_addr), .o_last_valid(last_valid),
        .o_sram_addr(sram_addr), .io_sram_dq(sram_dq),
        .o_sram_ce_n(ce_n), .o_sram_we_n(we_n), .o_sram_oe_n(oe_n),
        .o_sram_lb_n(lb_n), .o_sram_ub_n(ub_n)
    );

    // SRAM model: 256 words; unwritten locations read back as {8'hC0, addr[7:0]}
    logic [15:0] mem [256];
    bit          wr_flag [256];
    logic [15:0] rd_val;
    always_comb rd_val = wr_flag[sram_addr[7:0]] ? mem[sram_addr[7:0]] : {8'hC0, sram_addr[7:0]};
    assign sram_dq = (!ce_n && !oe_n && we_n) ? rd_val : 16'hzzzz;
    always @(posedge clk) begin
        if (!ce_n && !we_n) begin
            mem[sram_addr[7:0]]     <= sram_dq;
            wr_flag[sram_addr[7:0]] <= 1'b1;
        end
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    logic [15:0] exp_q [$];
    byte         ord_exp [$];
    byte         ord_got [$];
    logic [15:0] rd_got [$];
    bit          mon_en = 1'b0;
    int          dbl_ack = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (rec_ack) ord_got.push_back(8'h57);
            if (dsp_ack) begin
                ord_got.push_back(8'h52);
                rd_got.push_back(dsp_data);
            end
            if (rec_ack && dsp_ack) dbl_ack++;
        end
    end

    task automatic do_write(input logic [19:0] a, input logic [15:0] d, input bit clr_at_done,
                            output int lat, output int we_lo);
        rec_addr = a; rec_data = d; rec_req = 1'b1;
        lat = 0; we_lo = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (!we_n) we_lo++;
            clear = clr_at_done && (lat == 2);
            if (rec_ack) break;
        end
        rec_req = 1'b0; clear = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_read(input string tag, input logic [19:0] a, input logic [15:0] exp,
                           output int lat, output int ce_lo, output int oe_lo);
        exp_q.push_back(exp);
        dsp_addr = a; dsp_req = 1'b1;
        lat = 0; ce_lo = 0; oe_lo = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (!ce_n) ce_lo++;
            if (!oe_n) oe_lo++;
            if (dsp_ack) break;
        end
        chk(tag, dsp_data, exp_q.pop_front());
        dsp_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int lat, lo, ce_lo, oe_lo, ack_seen;

        // Reset state
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ctrl", {ce_n, we_n, oe_n, lb_n, ub_n}, 5'b11111);
        chk("rst_addr", sram_addr, 20'h0);
        chk("rst_acks", {rec_ack, dsp_ack}, 2'b00);
        chk("rst_data", dsp_data, 16'h0);
        chk("rst_last", {last_valid, last_addr}, 21'h0);
        chk("rst_dq_oe", dut.dq_oe, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Single write
        do_write(20'h00010, 16'hA5A5, 1'b0, lat, lo);
        chk("wr1_lat", lat, 3);
        chk("wr1_we_low", lo, 1);
        chk("wr1_mem", mem[8'h10], 16'hA5A5);
        chk("wr1_last", {last_valid, last_addr}, {1'b1, 20'h00010});

        // Write then read back; lower address leaves the extent alone
        do_write(20'h00003, 16'h1234, 1'b0, lat, lo);
        chk("wr2_last", last_addr, 20'h00010);
        do_read("rd1_data", 20'h00003, 16'h1234, lat, ce_lo, oe_lo);
        chk("rd1_lat", lat, 3);
        chk("rd1_oe_low", oe_lo, 2);
        do_read("rd2_data", 20'h00010, 16'hA5A5, lat, ce_lo, oe_lo);

        // Both requests held: W,W,W,W,R repeating
        for (int r = 0; r < 2; r++) begin
            for (int w = 0; w < 4; w++) ord_exp.push_back(8'h57);
            ord_exp.push_back(8'h52);
        end
        mon_en = 1'b1;
        rec_addr = 20'h00020; rec_data = 16'hBEEF; dsp_addr = 20'h00003;
        rec_req = 1'b1; dsp_req = 1'b1;
        for (int i = 0; i < 200 && ord_got.size() < 10; i++) begin
            @(negedge clk);
            #1;
        end
        rec_req = 1'b0; dsp_req = 1'b0;
        repeat (3) @(negedge clk);
        mon_en = 1'b0;
        chk("starve_count", ord_got.size(), 10);
        for (int i = 0; i < 10; i++)
            chk($sformatf("starve_ord%0d", i), (i < ord_got.size()) ? ord_got[i] : 8'h00, ord_exp[i]);
        chk("starve_dbl", dbl_ack, 0);
        chk("starve_rd", (rd_got.size() > 0) ? rd_got[0] : 16'hxxxx, 16'h1234);
        chk("starve_last", last_addr, 20'h00020);

        // Clear alone, then clear coinciding with a write completion
        clear = 1'b1; @(negedge clk); clear = 1'b0;
        chk("clr_last", {last_valid, last_addr}, 21'h0);
        do_write(20'h00030, 16'h3030, 1'b0, lat, lo);
        chk("wr30_last", last_addr, 20'h00030);
        do_write(20'h00020, 16'h2020, 1'b1, lat, lo);
        chk("clrwr_lat", lat, 3);
        chk("clrwr_last", {last_valid, last_addr}, {1'b1, 20'h00020});

        // Reads against the recorded extent
        clear = 1'b1; @(negedge clk); clear = 1'b0;
`ifdef SRAM_BOUND_CHECK_EN
        do_read("oob_empty", 20'h00000, 16'h0000, lat, ce_lo, oe_lo);
        chk("oob_empty_ce", ce_lo, 0);
`else
        do_read("oob_empty", 20'h00000, 16'hC000, lat, ce_lo, oe_lo);
        chk("oob_empty_ce", ce_lo, 2);
`endif
        do_write(20'h00005, 16'h0505, 1'b0, lat, lo);
        chk("b5_last", last_addr, 20'h00005);
`ifdef SRAM_BOUND_CHECK_EN
        do_read("oob9_data", 20'h00009, 16'h0000, lat, ce_lo, oe_lo);
        chk("oob9_ce", ce_lo, 0);
`else
        do_read("oob9_data", 20'h00009, 16'hC009, lat, ce_lo, oe_lo);
        chk("oob9_ce", ce_lo, 2);
`endif
        chk("oob9_lat", lat, 3);
        do_read("inb5_data", 20'h00005, 16'h0505, lat, ce_lo, oe_lo);
        chk("inb5_ce", ce_lo, 2);

        // Reset asserted during S_WR1
        rec_addr = 20'h00040; rec_data = 16'h5555; rec_req = 1'b1;
        @(negedge clk);
        chk("rstwr_pre_we", we_n, 1'b0);
        #1 rst = 1'b1;
        #1;
        chk("rstwr_ctrl", {ce_n, we_n, oe_n, lb_n, ub_n}, 5'b11111);
        chk("rstwr_dq_oe", dut.dq_oe, 1'b0);
        ack_seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (rec_ack) ack_seen++;
        end
        rec_req = 1'b0; rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (rec_ack) ack_seen++;
        end
        chk("rstwr_noack", ack_seen, 0);
        chk("rstwr_state", 32'(dut.state), 32'(S_IDLE));
        chk("rstwr_nomem", wr_flag[8'h40], 1'b0);
        chk("rstwr_last", {last_valid, last_addr}, 21'h0);
        do_write(20'h00011, 16'h1111, 1'b0, lat, lo);
        chk("post_rst_lat", lat, 3);
        chk("post_rst_mem", mem[8'h11], 16'h1111);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
